conv_compute_module: RTL and testbench

//  Compute stage directly downstream of Memory_module. Consumes the 4x4 pixel tile (DATA) and
//  3x3 kernel (FILTER), runs a valid 3x3 convolution into a 2x2 map with one MAC per cycle,
//  and returns ret22 (2x2 max-pool of the map) and ret33 (sum of the map).
//  ret22/ret33 feed Memory_module.inret22/inret33. Handshake: MS in, CS out.

---
 rtl/conv_compute_module.sv | 160 ++++++++++++++++
 tb/tb_conv_compute_module.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/conv_compute_module.sv
// 3x3 valid convolution of a 4x4 tile into a 2x2 map, one MAC per cycle; returns map max (ret22) and map sum (ret33). RELU_EN clamps negative convs.
// Latency: CS=DONE with results 38 edges after the MS==LOADED capture edge (capture + 36 MAC + 1 finish).
// Backpressure: results and CS=DONE hold until MS==STORED; MS==LOADED while busy/done is ignored.
module conv_compute_module #(
    parameter int PW = 8,
    parameter int KW = 8,
    parameter int RW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           MS,
    input  logic [16*PW-1:0]     DATA,
    input  logic [9*KW-1:0]      FILTER,
    output logic [2:0]           CS,
    output logic signed [RW-1:0] ret22,
    output logic signed [RW-1:0] ret33
);

    localparam logic [2:0] MS_LOADED = 3'd1;
    localparam logic [2:0] MS_STORED = 3'd2;
    localparam logic [2:0] CS_IDLE   = 3'd0;
    localparam logic [2:0] CS_BUSY   = 3'd1;
    localparam logic [2:0] CS_DONE   = 3'd2;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_FIN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [16*PW-1:0]     r_data;
    logic [9*KW-1:0]      r_filt;
    logic [3:0]           r_t;
    logic [1:0]           r_p;
    logic signed [RW-1:0] r_acc;
    logic signed [RW-1:0] r_map [4];
    logic [2:0]           r_cs;
    logic signed [RW-1:0] r_ret22;
    logic signed [RW-1:0] r_ret33;

    logic [1:0]           w_ki;
    logic [1:0]           w_kj;
    logic [1:0]           w_row;
    logic [1:0]           w_col;
    logic [3:0]           w_pix_idx;
    logic [PW-1:0]        w_pix;
    logic signed [KW-1:0] w_k;
    logic signed [PW+KW:0] w_prod;
    logic signed [RW-1:0] w_acc_nxt;
    logic signed [RW-1:0] w_conv;
    logic signed [RW-1:0] w_max;
    logic signed [RW-1:0] w_sum;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (MS == MS_LOADED) w_state_nxt = S_MAC;
            S_MAC:   if (r_p == 2'd3 && r_t == 4'd8) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_DONE;
            S_DONE:  if (MS == MS_STORED) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Tap t maps to kernel (i,j) = (t/3, t%3); kernel bit offset is simply t*KW.
    always_comb begin
        w_ki = 2'd0;
        w_kj = 2'd0;
        case (r_t)
            4'd1: w_kj = 2'd1;
            4'd2: w_kj = 2'd2;
            4'd3: w_ki = 2'd1;
            4'd4: begin w_ki = 2'd1; w_kj = 2'd1; end
            4'd5: begin w_ki = 2'd1; w_kj = 2'd2; end
            4'd6: w_ki = 2'd2;
            4'd7: begin w_ki = 2'd2; w_kj = 2'd1; end
            4'd8: begin w_ki = 2'd2; w_kj = 2'd2; end
            default: ;
        endcase
    end

    assign w_row     = w_ki + {1'b0, r_p[1]};
    assign w_col     = w_kj + {1'b0, r_p[0]};
    assign w_pix_idx = {w_row, w_col};
    assign w_pix     = r_data[w_pix_idx*PW +: PW];
    assign w_k       = r_filt[r_t*KW +: KW];
    assign w_prod    = $signed({1'b0, w_pix}) * w_k;
    assign w_acc_nxt = r_acc + {{(RW-PW-KW-1){w_prod[PW+KW]}}, w_prod};

`ifdef RELU_EN
    assign w_conv = w_acc_nxt[RW-1] ? '0 : w_acc_nxt;
`else
    assign w_conv = w_acc_nxt;
`endif

    // Strict greater-than keeps the earlier entry on ties.
    always_comb begin
        w_max = r_map[0];
        for (int i = 1; i < 4; i++) begin
            if (r_map[i] > w_max) w_max = r_map[i];
        end
    end

    assign w_sum = r_map[0] + r_map[1] + r_map[2] + r_map[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_filt  <= '0;
            r_t     <= '0;
            r_p     <= '0;
            r_acc   <= '0;
            r_cs    <= CS_IDLE;
            r_ret22 <= '0;
            r_ret33 <= '0;
            for (int i = 0; i < 4; i++) r_map[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (MS == MS_LOADED) begin
                        r_data <= DATA;
                        r_filt <= FILTER;
                        r_acc  <= '0;
                        r_t    <= '0;
                        r_p    <= '0;
                        r_cs   <= CS_BUSY;
                    end
                end
                S_MAC: begin
                    if (r_t == 4'd8) begin
                        r_map[r_p] <= w_conv;
                        r_acc      <= '0;
                        r_t        <= '0;
                        r_p        <= r_p + 2'd1;
                    end else begin
                        r_acc <= w_acc_nxt;
                        r_t   <= r_t + 4'd1;
                    end
                end
                S_FIN: begin
                    r_ret22 <= w_max;
                    r_ret33 <= w_sum;
                    r_cs    <= CS_DONE;
                end
                S_DONE: begin
                    if (MS == MS_STORED) r_cs <= CS_IDLE;
                end
                default: r_cs <= CS_IDLE;
            endcase
        end
    end

    assign CS    = r_cs;
    assign ret22 = r_ret22;
    assign ret33 = r_ret33;

endmodule

// File: tb/tb_conv_compute_module.sv
// Directed bench for conv_compute_module; expectations follow RELU_EN when defined.
module tb_conv_compute_module;

    logic               clk = 1'b0;
    logic               rst;
    logic [2:0]         MS;
    logic [127:0]       DATA;
    logic [71:0]        FILTER;
    logic [2:0]         CS;
    logic signed [31:0] ret22;
    logic signed [31:0] ret33;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    conv_compute_module dut (
        .clk    (clk),
        .rst    (rst),
        .MS     (MS),
        .DATA   (DATA),
        .FILTER (FILTER),
        .CS     (CS),
        .ret22  (ret22),
        .ret33  (ret33)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: MS pulsed; mode 1: MS held at 1 through DONE; mode 2: inputs scrambled during MAC
    task automatic run(input string tag, input logic [127:0] d, input logic [71:0] f,
                       input int mode, input logic [31:0] e22, input logic [31:0] e33);
        DATA   = d;
        FILTER = f;
        MS     = 3'd1;
        tick();
        if (mode != 1) MS = 3'd0;
        check({tag, "_busy"}, {29'd0, CS}, 32'd1);
        for (int i = 0; i < 36; i++) begin
            if (mode == 2) begin
                DATA   = {$urandom, $urandom, $urandom, $urandom};
                FILTER = {$urandom, $urandom, $urandom};
                MS     = (i % 2 == 1) ? 3'd2 : 3'd1;
            end
            tick();
        end
        check({tag, "_edge37"}, {29'd0, CS}, 32'd1);
        if (mode == 2) MS = 3'd0;
        tick();
        check({tag, "_done"}, {29'd0, CS}, 32'd2);
        check({tag, "_ret22"}, ret22, e22);
        check({tag, "_ret33"}, ret33, e33);
        repeat (3) tick();
        check({tag, "_hold"}, {29'd0, CS}, 32'd2);
        MS = 3'd2;
        tick();
        MS = 3'd0;
        check({tag, "_idle"}, {29'd0, CS}, 32'd0);
        check({tag, "_kept22"}, ret22, e22);
        check({tag, "_kept33"}, ret33, e33);
    endtask

    logic [127:0] d_ones, d_ramp, d_ff;
    logic [71:0]  f_ones, f_ctr, f_ff;
    logic [31:0]  e3_22, e3_33;

    initial begin
        d_ones = {16{8'h01}};
        f_ones = {9{8'h01}};
        d_ff   = {16{8'hFF}};
        f_ff   = {9{8'hFF}};
        d_ramp = '0;
        for (int i = 0; i < 16; i++) d_ramp[8*i +: 8] = 8'(i);
        f_ctr = '0;
        f_ctr[32 +: 8] = 8'd2;
`ifdef RELU_EN
        e3_22 = 32'd0;
        e3_33 = 32'd0;
`else
        e3_22 = 32'hFFFFF709;
        e3_33 = 32'hFFFFDC24;
`endif

        rst    = 1'b1;
        MS     = 3'd0;
        DATA   = '0;
        FILTER = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_cs", {29'd0, CS}, 32'd0);
        check("rst_ret22", ret22, 32'd0);
        check("rst_ret33", ret33, 32'd0);

        MS = 3'd2;
        tick();
        check("idle_ms2", {29'd0, CS}, 32'd0);
        MS = 3'd5;
        tick();
        check("idle_ms5", {29'd0, CS}, 32'd0);
        MS = 3'd0;
        tick();

        run("t1", d_ones, f_ones, 0, 32'd9, 32'd36);
        run("t2", d_ramp, f_ctr, 0, 32'd20, 32'd60);
        run("t3", d_ff, f_ff, 0, e3_22, e3_33);
        run("t4a", d_ones, f_ones, 1, 32'd9, 32'd36);
        run("t4b", d_ramp, f_ctr, 0, 32'd20, 32'd60);

        DATA   = d_ones;
        FILTER = f_ones;
        MS     = 3'd1;
        tick();
        MS = 3'd0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_cs", {29'd0, CS}, 32'd0);
        check("abort_ret22", ret22, 32'd0);
        check("abort_ret33", ret33, 32'd0);
        tick();
        check("abort_stay", {29'd0, CS}, 32'd0);

        run("t5", d_ones, f_ones, 0, 32'd9, 32'd36);
        run("t6", d_ramp, f_ctr, 2, 32'd20, 32'd60);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
